// File: rtl/fft_pkg.sv
// Shared FFT chain definitions: default frame geometry, sample type
// and the bit-reversal helper reused by the FFT stages.
package fft_pkg;

    localparam int SAMPLES_DEF = 4;
    localparam int WIDTH_DEF   = 32;

    typedef logic [WIDTH_DEF-1:0] sample_t;

    function automatic logic [31:0] bitrev(
        input logic [31:0] idx,
        input int          nbits
    );
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r[nbits-1-i] = idx[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One SAMPLES x WIDTH register bank with indexed write and whole-bank clear.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int SAMPLES = SAMPLES_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int IW      = $clog2(SAMPLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IW-1:0]    idx,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr,
    output logic [WIDTH-1:0] data [SAMPLES-1:0]
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SAMPLES; i++) begin
                data[i] <= '0;
            end
        end else if (we) begin
            data[idx] <= wdata;
        end else if (clr) begin
            for (int i = 0; i < SAMPLES; i++) begin
                data[i] <= '0;
            end
        end
    end

endmodule

// File: rtl/fft_sample_framer.sv
// Ping-pong sample framer feeding the FFT chain.
// Optional FFT_FRAMER_BITREV_EN stores samples in bit-reversed order.
module fft_sample_framer
    import fft_pkg::*;
#(
    parameter int SAMPLES = SAMPLES_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] frame_out [SAMPLES-1:0],
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [15:0]      frame_count
);

    localparam int IW = $clog2(SAMPLES);

    logic [IW-1:0]    fill_idx;
    logic [IW-1:0]    wr_idx;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic [1:0]       full_n;
    logic [15:0]      count;
    logic             accept;
    logic             last;
    logic             rel;
    logic [WIDTH-1:0] b0 [SAMPLES-1:0];
    logic [WIDTH-1:0] b1 [SAMPLES-1:0];

    assign in_ready    = !full[wr_bank];
    assign frame_valid = full[rd_bank];
    assign frame_count = count;

    // flush beats a same-cycle sample
    assign accept = in_valid && in_ready && !flush;
    assign last   = accept && (fill_idx == IW'(SAMPLES-1));
    assign rel    = frame_valid && frame_ready;

`ifdef FFT_FRAMER_BITREV_EN
    assign wr_idx = IW'(bitrev(32'(fill_idx), IW));
`else
    assign wr_idx = fill_idx;
`endif

    // completion and release never hit the same bank
    always_comb begin
        full_n = full;
        if (rel) full_n[rd_bank] = 1'b0;
        if (last) full_n[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_idx <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full     <= '0;
            count    <= '0;
        end else begin
            full <= full_n;
            if (flush) begin
                fill_idx <= '0;
            end else if (accept) begin
                fill_idx <= fill_idx + 1'b1;
            end
            if (last) wr_bank <= ~wr_bank;
            if (rel) begin
                rd_bank <= ~rd_bank;
                count   <= count + 16'd1;
            end
        end
    end

    fft_frame_bank #(
        .SAMPLES(SAMPLES),
        .WIDTH  (WIDTH),
        .IW     (IW)
    ) u_bank0 (
        .clk  (clk),
        .rst  (rst),
        .we   (accept && !wr_bank),
        .idx  (wr_idx),
        .wdata(in_data),
        .clr  (rel && !rd_bank),
        .data (b0)
    );

    fft_frame_bank #(
        .SAMPLES(SAMPLES),
        .WIDTH  (WIDTH),
        .IW     (IW)
    ) u_bank1 (
        .clk  (clk),
        .rst  (rst),
        .we   (accept && wr_bank),
        .idx  (wr_idx),
        .wdata(in_data),
        .clr  (rel && rd_bank),
        .data (b1)
    );

    always_comb begin
        for (int i = 0; i < SAMPLES; i++) begin
            frame_out[i] = rd_bank ? b1[i] : b0[i];
        end
    end

endmodule

// File: tb/tb_fft_sample_framer.sv
// Scoreboard bench for fft_sample_framer (SAMPLES=4, WIDTH=32).
module tb_fft_sample_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] frame_out [3:0];
    logic        frame_valid;
    logic        frame_ready;
    logic [15:0] frame_count;

    int total = 0;
    int passed = 0;
    int stalls = 0;
    int m_n = 0;
    logic [127:0] m_cur = '0;
    logic [127:0] exp_q [$];
    logic [127:0] mon_e;

    fft_sample_framer #(.SAMPLES(4), .WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .frame_out  (frame_out),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic int pos(input int k);
`ifdef FFT_FRAMER_BITREV_EN
        return ((k & 1) << 1) | ((k >> 1) & 1);
`else
        return k;
`endif
    endfunction

    function automatic logic [127:0] cur();
        return {frame_out[3], frame_out[2],
                frame_out[1], frame_out[0]};
    endfunction

    function automatic logic [127:0] exp4(
        input logic [31:0] a0, a1, a2, a3
    );
        logic [127:0] r;
        r = '0;
        r[pos(0)*32 +: 32] = a0;
        r[pos(1)*32 +: 32] = a1;
        r[pos(2)*32 +: 32] = a2;
        r[pos(3)*32 +: 32] = a3;
        return r;
    endfunction

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s actual=%0h required=%0h",
                      nm, act, want);
    endtask

    task automatic model_add(input logic [31:0] d);
        m_cur[pos(m_n)*32 +: 32] = d;
        m_n++;
        if (m_n == 4) begin
            exp_q.push_back(m_cur);
            m_n = 0;
            m_cur = '0;
        end
    endtask

    task automatic send(input logic [31:0] d);
        logic rdy;
        int   budget;
        budget = 50;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            rdy = in_ready;
            if (!rdy) stalls++;
            @(posedge clk);
            #1;
            budget--;
        end while (!rdy && budget > 0);
        if (rdy) model_add(d);
        else begin
            total++;
            $display("FAIL send_timeout actual=stalled required=accept %0d", d);
        end
    endtask

    task automatic release_n(input int n);
        frame_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL frame_unexpected actual=%0h required=none",
                         cur());
            end else begin
                mon_e = exp_q.pop_front();
                chk("frame_data", cur(), mon_e);
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        flush = 1'b0;
        frame_ready = 1'b0;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_frame_valid", 128'(frame_valid), 128'd0);
        chk("rst_frame_count", 128'(frame_count), 128'd0);
        chk("rst_frame_out", cur(), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic frame
        send(100); send(150); send(200); send(250);
        in_valid = 1'b0;
        chk("basic_valid", 128'(frame_valid), 128'd1);
`ifdef FFT_FRAMER_BITREV_EN
        chk("basic_out", cur(),
            {32'd250, 32'd150, 32'd200, 32'd100});
`else
        chk("basic_out", cur(),
            {32'd250, 32'd200, 32'd150, 32'd100});
`endif
        release_n(1);
        chk("basic_count", 128'(frame_count), 128'd1);
        chk("basic_drained", 128'(frame_valid), 128'd0);

        // backpressure
        for (int i = 0; i < 8; i++) send(32'(11 + i));
        in_valid = 1'b1;
        in_data = 32'd19;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_hold", cur(), exp4(11, 12, 13, 14));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        release_n(2);
        chk("bp_count", 128'(frame_count), 128'd3);
        for (int i = 0; i < 4; i++) send(32'(19 + i));
        in_valid = 1'b0;
        chk("bp_f3_valid", 128'(frame_valid), 128'd1);
        release_n(1);
        chk("bp_count2", 128'(frame_count), 128'd4);

        // completion of bank 1 with release of bank 0
        for (int i = 0; i < 7; i++) send(32'(40 + i));
        frame_ready = 1'b1;
        send(47);
        frame_ready = 1'b0;
        in_valid = 1'b0;
        chk("sim_valid", 128'(frame_valid), 128'd1);
        chk("sim_out", cur(), exp4(44, 45, 46, 47));
        chk("sim_count", 128'(frame_count), 128'd5);
        release_n(1);
        chk("sim_count2", 128'(frame_count), 128'd6);

        // flush discards partial and same-cycle sample
        send(100); send(150);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 32'd999;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        m_n = 0;
        m_cur = '0;
        send(1); send(2); send(3); send(4);
        in_valid = 1'b0;
        chk("flush_out", cur(), exp4(1, 2, 3, 4));
        release_n(1);

        // async reset mid-frame
        for (int i = 0; i < 7; i++) send(32'(50 + i));
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_in_ready", 128'(in_ready), 128'd1);
        chk("ar_valid", 128'(frame_valid), 128'd0);
        chk("ar_count", 128'(frame_count), 128'd0);
        chk("ar_out", cur(), 128'd0);
        exp_q.delete();
        m_n = 0;
        m_cur = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(70); send(71); send(72); send(73);
        in_valid = 1'b0;
        chk("ar_clean", cur(), exp4(70, 71, 72, 73));
        release_n(1);

        // full-rate stream
        stalls = 0;
        frame_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(32'(1000 + 3 * i));
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        frame_ready = 1'b0;
        chk("tp_stalls", 128'(stalls), 128'd0);
        chk("tp_count", 128'(frame_count), 128'd17);
        chk("tp_q_empty", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fft_sample_framer.md
Name: fft_sample_framer

Overview:
- Producer-side front end for the FFT stage chain.
- Accepts a serial stream of time-domain samples over a valid/ready handshake and assembles them into frames of SAMPLES words.
- Presents each completed frame as an unpacked array, which is the sampleInputs format consumed by the FFT stage.
- Ping-pong (two-bank) buffering lets the next frame fill while the FFT consumes the current one.

Parameters:
- SAMPLES, 4: words per frame; power of two, at least 2.
- WIDTH, 32: bits per sample word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  WIDTH  serial sample word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  framer can accept a sample this cycle.
- flush  input  1  synchronous; discards the partially filled write bank.
- frame_out  output  WIDTH x SAMPLES  unpacked array [SAMPLES-1:0] of [WIDTH-1:0]; the oldest completed frame.
- frame_valid  output  1  frame_out holds a complete frame.
- frame_ready  input  1  consumer takes the frame this cycle.
- frame_count  output  16  number of frames released since reset; wraps modulo 2^16.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - wr_bank = 0, rd_bank = 0, both full flags = 0, fill index = 0.
  - in_ready = 1, frame_valid = 0, frame_count = 0.
  - frame_out contents = 0.
- Sample accept: a sample is accepted when in_valid && in_ready.
  - in_data is written to bank[wr_bank][fill_idx].
  - fill_idx increments; its width is $clog2(SAMPLES).
- Bank completion: when the SAMPLES-th sample is accepted:
  - full[wr_bank] is set, fill_idx wraps to 0, and wr_bank toggles.
  - frame_valid rises on the next cycle, so latency from the last sample to frame_valid is 1 cycle.
- in_ready = !full[wr_bank]. It is combinational from registers only and never depends on in_valid.
- frame_valid = full[rd_bank]. frame_out = bank[rd_bank], registered storage driven directly.
  - frame_out is stable while frame_valid=1 and frame_ready=0.
- Frame release: when frame_valid && frame_ready:
  - full[rd_bank] clears, rd_bank toggles, frame_count increments.
- Both banks full: in_ready = 0 and samples stall; none are dropped.
- Simultaneous completion and release in the same cycle: both take effect.
  - Example: the last sample completes bank 1 while bank 0 is released. Then full[1] is set, full[0] is cleared, rd_bank becomes 1 and frame_valid stays 1.
- Full rate: sustained 1 sample/cycle is achieved if the consumer releases each frame within SAMPLES cycles.
- flush:
  - Resets fill_idx to 0 and leaves full banks and rd_bank untouched.
  - A sample accepted in the same cycle as flush is discarded; flush wins.
  - Flush while fill_idx = 0 has no effect.
- Reset mid-operation: all state returns to reset values immediately; partial and full frames are lost.
- No arithmetic on sample data; words pass through bit-exact.

Optional Feature:
- Macro: FFT_FRAMER_BITREV_EN.
- Defined: the sample with arrival index k is stored at frame_out[bitrev(k)], reversed over $clog2(SAMPLES) bits. Frames are delivered in bit-reversed order for an in-place radix-2 DIT chain.
- Undefined: natural order, sample k is stored at frame_out[k].
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package fft_pkg:
  - Default SAMPLES/WIDTH localparams.
  - sample_t typedef (logic [WIDTH-1:0]).
  - Function bitrev(idx, nbits), reused by the FFT stages.
- One natural sub-module, fft_frame_bank: a single SAMPLES x WIDTH register bank with write-enable, index and clear.
  - The framer instantiates two of them plus the control logic.

Test Plan:
- Basic frame, SAMPLES=4: stream 100,150,200,250 with in_valid held high. frame_valid rises 1 cycle after 250 is accepted, frame_out = {250,200,150,100} in natural order. With FFT_FRAMER_BITREV_EN defined, frame_out[0..3] = 100,200,150,250.
- Backpressure: frame_ready held 0, stream 12 samples. Frames 1 and 2 fill, in_ready drops after the 8th sample, and samples 9–12 stall. frame_out holds frame 1 unchanged. After 2 releases, frame_count = 2 and frame 3 completes.
- Simultaneous completion and release: last sample of bank 1 arrives in the same cycle frame_ready takes bank 0. frame_valid stays high, the next frame_out = bank 1 data, and no sample is lost.
- Flush: accept 100,150, then flush=1 with in_valid=1 on 999. The next 4 samples 1,2,3,4 form a frame {4,3,2,1}; 999 is absent.
- Async reset mid-frame: assert rst between clock edges after 3 samples. in_ready=1, frame_valid=0 and frame_count=0 immediately. The next 4 samples form a clean frame.
- Throughput: continuous stream of 64 samples with frame_ready tied 1. in_ready is never low, frame_count = 16, and every frame matches a scoreboard built from the arrival order.
